// File: rtl/bldc_hall_pkg.sv
// Shared definitions for the hall-sensor decoder: code map, angle table,
// FSM encoding and sector modulo-6 helpers.
package bldc_hall_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Sector ring is 0..5; these bound the modulo-6 wrap.
    localparam logic [2:0] SECTOR_FIRST = 3'd0;
    localparam logic [2:0] SECTOR_LAST  = 3'd5;

    // Sector start angles on the 16-bit electrical-revolution scale.
    localparam logic [15:0] ANGLE_S0 = 16'd0;
    localparam logic [15:0] ANGLE_S1 = 16'd10923;
    localparam logic [15:0] ANGLE_S2 = 16'd21845;
    localparam logic [15:0] ANGLE_S3 = 16'd32768;
    localparam logic [15:0] ANGLE_S4 = 16'd43691;
    localparam logic [15:0] ANGLE_S5 = 16'd54613;

    typedef struct packed {
        logic       valid;
        logic [2:0] sector;
    } hall_dec_t;

    // Hall code {A,B,C} to sector; 000 and 111 cannot occur on a healthy motor.
    function automatic hall_dec_t hall_decode(input logic [2:0] code);
        hall_dec_t d;
        d.valid  = 1'b1;
        d.sector = 3'd0;
        case (code)
            3'b001:  d.sector = 3'd0;
            3'b011:  d.sector = 3'd1;
            3'b010:  d.sector = 3'd2;
            3'b110:  d.sector = 3'd3;
            3'b100:  d.sector = 3'd4;
            3'b101:  d.sector = 3'd5;
            default: d.valid  = 1'b0;
        endcase
        return d;
    endfunction

    function automatic logic [15:0] sector_angle(input logic [2:0] s);
        logic [15:0] a;
        case (s)
            3'd0:    a = ANGLE_S0;
            3'd1:    a = ANGLE_S1;
            3'd2:    a = ANGLE_S2;
            3'd3:    a = ANGLE_S3;
            3'd4:    a = ANGLE_S4;
            3'd5:    a = ANGLE_S5;
            default: a = ANGLE_S0;
        endcase
        return a;
    endfunction

    function automatic logic [2:0] sector_inc(input logic [2:0] s);
        return (s == SECTOR_LAST) ? SECTOR_FIRST : s + 3'd1;
    endfunction

    function automatic logic [2:0] sector_dec(input logic [2:0] s);
        return (s == SECTOR_FIRST) ? SECTOR_LAST : s - 3'd1;
    endfunction

endpackage

// File: rtl/bldc_hall_debounce.sv
// Hall input conditioning: 2-FF synchronizer followed by a stability counter.
// A code is accepted once it has been seen DEBOUNCE consecutive samples and
// differs from the last accepted code; accept is a one-cycle strobe.
// With BLDC_HALL_GLITCH_CNT_EN defined a glitch pulse is also produced
// whenever the code changes before reaching stability.
module bldc_hall_debounce #(
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] hall,
    output logic [2:0] code,
    output logic       accept
`ifdef BLDC_HALL_GLITCH_CNT_EN
    ,
    output logic       glitch
`endif
);
    import bldc_hall_pkg::*;

    localparam logic [7:0] DB = 8'(DEBOUNCE);

    logic [2:0] sync1, sync2, cand;
    logic [7:0] cnt, cnt_nxt;
    logic       reached;

    // Run length of the current synchronized code and first-time stability detect
    always_comb begin
        cnt_nxt = (sync2 != cand) ? 8'd1 : ((cnt < DB) ? cnt + 8'd1 : cnt);
        reached = (cnt_nxt == DB) && ((cnt != DB) || (sync2 != cand));
    end

    // Synchronizer, candidate tracking and accept strobe. The counter starts
    // saturated so the reset-state code is neither accepted nor a glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 3'b000;
            sync2  <= 3'b000;
            cand   <= 3'b000;
            cnt    <= DB;
            code   <= 3'b000;
            accept <= 1'b0;
        end else begin
            sync1  <= hall;
            sync2  <= sync1;
            cand   <= sync2;
            cnt    <= cnt_nxt;
            accept <= reached && (sync2 != code);
            if (reached && (sync2 != code))
                code <= sync2;
        end
    end

`ifdef BLDC_HALL_GLITCH_CNT_EN
    // Code abandoned before it became stable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) glitch <= 1'b0;
        else     glitch <= (sync2 != cand) && (cnt < DB);
    end
`endif

endmodule

// File: rtl/bldc_hall.sv
// Hall-sensor decoder for the BLDC driver feedback path. Produces electrical
// angle, sector, signed step position, direction and step period.
// Optional: BLDC_HALL_GLITCH_CNT_EN builds the rejected-glitch counter;
// without it glitch_cnt reads 0.
module bldc_hall #(
    parameter int          DEBOUNCE     = 4,
    parameter int          TIMEOUT      = 10000000,
    parameter logic [15:0] ANGLE_OFFSET = 16'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hall_a,
    input  logic        hall_b,
    input  logic        hall_c,
    input  logic        err_clear,
    output logic [15:0] feedback,
    output logic [2:0]  sector,
    output logic [31:0] position,
    output logic        direction,
    output logic [31:0] period,
    output logic        period_valid,
    output logic        error,
    output logic [15:0] glitch_cnt
);
    import bldc_hall_pkg::*;

    localparam logic [31:0] TO = 32'(TIMEOUT);

    state_t     state, state_nxt;
    logic [2:0] acc_code;
    logic       accept;
    hall_dec_t  dec;
    logic       ev_load, ev_fwd, ev_rev, ev_skip, err_set;
    logic [2:0] sector_nxt;
    logic [31:0] pcnt;

`ifdef BLDC_HALL_GLITCH_CNT_EN
    logic glitch;
`endif

    bldc_hall_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .hall   ({hall_a, hall_b, hall_c}),
        .code   (acc_code),
        .accept (accept)
`ifdef BLDC_HALL_GLITCH_CNT_EN
        ,
        .glitch (glitch)
`endif
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_INIT;
        else     state <= state_nxt;
    end

    // FSM next state: leave INIT on the first valid accepted code
    always_comb begin
        state_nxt = state;
        if (state == ST_INIT && ev_load)
            state_nxt = ST_RUN;
    end

    // FSM outputs: classify each accepted code into load/step/skip/error events
    always_comb begin
        dec     = hall_decode(acc_code);
        ev_load = 1'b0;
        ev_fwd  = 1'b0;
        ev_rev  = 1'b0;
        ev_skip = 1'b0;
        err_set = 1'b0;
        if (accept) begin
            case (state)
                ST_INIT: begin
                    if (dec.valid) ev_load = 1'b1;
                    else           err_set = 1'b1;
                end
                ST_RUN: begin
                    if (!dec.valid)
                        err_set = 1'b1;
                    else if (dec.sector == sector_inc(sector))
                        ev_fwd = 1'b1;
                    else if (dec.sector == sector_dec(sector))
                        ev_rev = 1'b1;
                    else if (dec.sector != sector) begin
                        ev_skip = 1'b1;
                        err_set = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        sector_nxt = (ev_load || ev_fwd || ev_rev || ev_skip) ? dec.sector : sector;
    end

    // Sector, angle, position, direction, period measurement and sticky error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sector       <= 3'd0;
            feedback     <= ANGLE_OFFSET;
            position     <= 32'd0;
            direction    <= 1'b1;
            period       <= 32'd0;
            period_valid <= 1'b0;
            error        <= 1'b0;
            pcnt         <= 32'd0;
        end else begin
            sector   <= sector_nxt;
            feedback <= sector_angle(sector_nxt) + ANGLE_OFFSET;
            error    <= err_set | (error & ~err_clear);
            if (ev_fwd || ev_rev) begin
                position  <= ev_fwd ? position + 32'd1 : position - 32'd1;
                direction <= ev_fwd;
                // A saturated counter means the previous step is too old to time
                if ((ev_fwd == direction) && (pcnt < TO)) begin
                    period       <= pcnt + 32'd1;
                    period_valid <= 1'b1;
                end else begin
                    period_valid <= 1'b0;
                end
                pcnt <= 32'd0;
            end else if (ev_load || ev_skip) begin
                pcnt <= 32'd0;
            end else if (pcnt < TO) begin
                pcnt <= pcnt + 32'd1;
                if (pcnt == TO - 32'd1) begin
                    period       <= 32'd0;
                    period_valid <= 1'b0;
                end
            end
        end
    end

`ifdef BLDC_HALL_GLITCH_CNT_EN
    // Saturating count of rejected glitches, cleared along with the error
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            glitch_cnt <= 16'd0;
        else if (err_clear)
            glitch_cnt <= 16'd0;
        else if (glitch && glitch_cnt != 16'hFFFF)
            glitch_cnt <= glitch_cnt + 16'd1;
    end
`else
    assign glitch_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_bldc_hall.sv
// Directed-vector bench for bldc_hall (DEBOUNCE=4, TIMEOUT=3000).
module tb_bldc_hall;
    import bldc_hall_pkg::*;

    localparam int DEBOUNCE = 4;
    localparam int TIMEOUT  = 3000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hall_a = 1'b0, hall_b = 1'b0, hall_c = 1'b1;
    logic        err_clear = 1'b0;
    logic [15:0] feedback;
    logic [2:0]  sector;
    logic [31:0] position;
    logic        direction;
    logic [31:0] period;
    logic        period_valid;
    logic        error;
    logic [15:0] glitch_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    bldc_hall #(.DEBOUNCE(DEBOUNCE), .TIMEOUT(TIMEOUT), .ANGLE_OFFSET(16'd0)) dut (
        .clk          (clk),
        .rst          (rst),
        .hall_a       (hall_a),
        .hall_b       (hall_b),
        .hall_c       (hall_c),
        .err_clear    (err_clear),
        .feedback     (feedback),
        .sector       (sector),
        .position     (position),
        .direction    (direction),
        .period       (period),
        .period_valid (period_valid),
        .error        (error),
        .glitch_cnt   (glitch_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Apply a hall code {A,B,C} at the falling edge and hold it n cycles
    task automatic drive(input logic [2:0] c, input int n);
        {hall_a, hall_b, hall_c} = c;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_feedback", {16'd0, feedback}, 32'd0);
        check("rst_sector", {29'd0, sector}, 32'd0);
        check("rst_position", position, 32'd0);
        check("rst_direction", {31'd0, direction}, 32'd1);
        check("rst_period", period, 32'd0);
        check("rst_pvalid", {31'd0, period_valid}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_glitch", {16'd0, glitch_cnt}, 32'd0);
        check("rst_state", 32'(dut.state), 32'(ST_INIT));

        // First valid code loads sector 0 and enters RUN
        rst = 1'b0;
        drive(3'b001, 10);
        check("init_sector", {29'd0, sector}, 32'd0);
        check("init_feedback", {16'd0, feedback}, 32'd0);
        check("init_error", {31'd0, error}, 32'd0);
        check("init_position", position, 32'd0);
        check("init_state", 32'(dut.state), 32'(ST_RUN));

        // Forward run, steps 1000 cycles apart
        drive(3'b011, 1000);
        drive(3'b010, 1000);
        drive(3'b110, 1000);
        check("fwd_position", position, 32'd3);
        check("fwd_direction", {31'd0, direction}, 32'd1);
        check("fwd_period", period, 32'd1000);
        check("fwd_pvalid", {31'd0, period_valid}, 32'd1);
        check("fwd_feedback", {16'd0, feedback}, 32'd32768);
        check("fwd_sector", {29'd0, sector}, 32'd3);

        // Reversal invalidates the period but keeps its value
        drive(3'b010, 20);
        check("rev_position", position, 32'd2);
        check("rev_direction", {31'd0, direction}, 32'd0);
        check("rev_pvalid", {31'd0, period_valid}, 32'd0);
        check("rev_period", period, 32'd1000);
        check("rev_feedback", {16'd0, feedback}, 32'd21845);

        // Invalid code: sticky error, outputs hold
        drive(3'b000, 20);
        check("inv_error", {31'd0, error}, 32'd1);
        check("inv_sector", {29'd0, sector}, 32'd2);
        check("inv_position", position, 32'd2);
        check("inv_feedback", {16'd0, feedback}, 32'd21845);

        // Clear in the very cycle a new invalid code (111) raises error: set wins.
        // Accept strobe is registered 6 edges after the pin change; error updates on the 7th.
        drive(3'b111, 6);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        repeat (5) @(negedge clk);
        check("clr_collide_error", {31'd0, error}, 32'd1);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        check("clr_clean_error", {31'd0, error}, 32'd0);

        // Walk back to sector 0 (two reverse steps), then skip to sector 3
        drive(3'b011, 20);
        drive(3'b001, 20);
        check("walk_sector", {29'd0, sector}, 32'd0);
        check("walk_position", position, 32'd0);
        drive(3'b110, 20);
        check("skip_error", {31'd0, error}, 32'd1);
        check("skip_sector", {29'd0, sector}, 32'd3);
        check("skip_position", position, 32'd0);
        check("skip_direction", {31'd0, direction}, 32'd0);
        check("skip_feedback", {16'd0, feedback}, 32'd32768);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;

        // 3-cycle pulse on hall_b (110 -> 100 -> 110) is rejected
        drive(3'b100, 3);
        drive(3'b110, 20);
        check("glitch_sector", {29'd0, sector}, 32'd3);
        check("glitch_position", position, 32'd0);
        check("glitch_error", {31'd0, error}, 32'd0);
`ifdef BLDC_HALL_GLITCH_CNT_EN
        check("glitch_cnt", {16'd0, glitch_cnt}, 32'd1);
`else
        check("glitch_cnt", {16'd0, glitch_cnt}, 32'd0);
`endif

        // Reversal to forward, then a same-direction step 500 cycles later
        drive(3'b100, 500);
        drive(3'b101, 20);
        check("p500_period", period, 32'd500);
        check("p500_pvalid", {31'd0, period_valid}, 32'd1);
        check("p500_position", position, 32'd2);

        // Hold past TIMEOUT: measurement dropped
        drive(3'b101, TIMEOUT);
        check("tmo_period", period, 32'd0);
        check("tmo_pvalid", {31'd0, period_valid}, 32'd0);

        // First step after timeout does not produce a period
        drive(3'b001, 20);
        check("post_tmo_position", position, 32'd3);
        check("post_tmo_pvalid", {31'd0, period_valid}, 32'd0);
        check("post_tmo_period", period, 32'd0);
        check("post_tmo_sector", {29'd0, sector}, 32'd0);

        // Reset mid-operation returns everything to reset values
        drive(3'b011, 20);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_position", position, 32'd0);
        check("mid_rst_sector", {29'd0, sector}, 32'd0);
        check("mid_rst_state", 32'(dut.state), 32'(ST_INIT));
        check("mid_rst_direction", {31'd0, direction}, 32'd1);
        rst = 1'b0;
        drive(3'b011, 10);
        check("mid_rst_reload_sector", {29'd0, sector}, 32'd1);
        check("mid_rst_reload_position", position, 32'd0);
        check("mid_rst_reload_feedback", {16'd0, feedback}, 32'd10923);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bldc_hall.md
Name: bldc_hall

Overview:
- Hall-sensor decoder for the BLDC driver's feedback input; it reads the three rotor hall sensors.
- Produces the rotor electrical angle on the same 16-bit feedback scale the driver consumes, plus sector, signed step position, direction and edge-to-edge period.
- Sits between the hall input pins and the BLDC driver's feedback/velocity path.

Parameters:
- DEBOUNCE, 4: consecutive clk cycles a synchronized hall code must be stable before it is accepted (1..255).
- TIMEOUT, 10000000: clk cycles without an accepted step before the motor is declared stopped.
- ANGLE_OFFSET, 0: 16-bit value added (mod 2^16) to the sector angle.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- hall_a  in  1  hall sensor A, asynchronous
- hall_b  in  1  hall sensor B, asynchronous
- hall_c  in  1  hall sensor C, asynchronous
- err_clear  in  1  clears sticky error
- feedback  out  16  electrical angle, 65536 = one electrical revolution
- sector  out  3  current sector 0..5
- position  out  32  signed accumulated step count
- direction  out  1  1 = forward (sector increasing), 0 = reverse
- period  out  32  clk cycles between the last two same-direction steps
- period_valid  out  1  period holds a valid measurement
- error  out  1  sticky: invalid code or skipped sector
- glitch_cnt  out  16  rejected-glitch count (see Optional Feature)

Behaviour:
- Reset values: feedback = ANGLE_OFFSET, sector = 0, position = 0, direction = 1, period = 0, period_valid = 0, error = 0, glitch_cnt = 0, FSM = INIT.
- Input path: 2-FF synchronizer on {hall_a, hall_b, hall_c}, then debounce.
  - A code is accepted after DEBOUNCE consecutive identical synchronized samples.
  - Latency from pin change to output update is 2 + DEBOUNCE + 1 cycles.
- Code map {A,B,C}: 001→0, 011→1, 010→2, 110→3, 100→4, 101→5. 000 and 111 are invalid.
- Angle table, indexed by sector: 0, 10923, 21845, 32768, 43691, 54613. feedback = table[sector] + ANGLE_OFFSET, registered.
- FSM INIT:
  - First valid accepted code loads sector, goes to RUN.
  - No step, no period update.
  - Invalid codes in INIT set error and stay in INIT.
- FSM RUN, for each newly accepted code:
  - New sector == sector+1 mod 6: step forward; position += 1, direction = 1.
  - New sector == sector−1 mod 6: step reverse; position −= 1, direction = 0.
  - Same sector: no action.
  - Skip of ±2 or 3 sectors: error = 1; sector resyncs to the new code; position, direction and period are unchanged; the period counter restarts.
  - Invalid code: error = 1; all outputs hold.
- Period counter counts clk cycles since the last step and saturates at TIMEOUT.
  - On a step with unchanged direction and counter < TIMEOUT: period = counter + 1, period_valid = 1.
  - On a reversal, or on the first step after a timeout: period_valid = 0; period is unchanged.
  - The counter resets to 0 on every step.
  - When the counter reaches TIMEOUT: period = 0, period_valid = 0.
- position wraps two's-complement (0x7FFFFFFF + 1 → 0x80000000).
- error is set by a skip or an invalid code and cleared by err_clear. If a clear and a new error occur in the same cycle, error = 1.
- Reset mid-operation: everything returns to reset values immediately, including the synchronizer and debounce state.

Optional Feature:
- Macro: BLDC_HALL_GLITCH_CNT_EN.
- Defined: glitch_cnt increments (saturating at 0xFFFF) each time the synchronized code changes before reaching DEBOUNCE stability; err_clear also zeroes it.
- Undefined: glitch_cnt is tied to 0 and no counter logic is built. The port is always present.

Decomposition:
- Package bldc_hall_pkg holds: the hall-code→sector map, the angle table constants, state encoding (INIT, RUN), and the sector modulo helper constants.
- One sub-module, bldc_hall_debounce: 3-bit synchronizer plus stability counter; outputs an accepted code and a one-cycle accept strobe (and the glitch pulse).

Test Plan:
- Reset, drive 001, wait 10 clk → sector = 0, feedback = 0, error = 0, position = 0, FSM = RUN.
- Forward sequence 001→011→010→110, each held 1000 clk, DEBOUNCE = 4 → position = 3, direction = 1, period = 1000, period_valid = 1, feedback = 32768.
- From sector 3 drive 010 → position = 2, direction = 0, period_valid = 0, period still 1000.
- Drive 000 for 20 clk → error = 1, outputs held; pulse err_clear together with a 111 code → error stays 1; clean err_clear → 0.
- From sector 0 jump to 110 → error = 1, sector = 3, position unchanged.
- Glitch 3-cycle pulse on hall_b with DEBOUNCE = 4 → no sector change; glitch_cnt = 1 with the macro, 0 without. Hold code for TIMEOUT clk → period = 0, period_valid = 0.
